// File: rtl/mul_pkg.sv
// Shared types and widths for the signed multiply-accumulate datapath.
package mul_pkg;

    localparam int unsigned PROD_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } mac_state_t;

endpackage

// File: rtl/signed_mac_acc_sat_add.sv
// Combinational signed adder with overflow flag.
// SIGNED_MAC_ACC_SAT_EN: clamp to the signed range on overflow instead of wrapping.
module sat_add #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W-1:0] raw;

    always_comb begin
        raw = a + b;
        // Same-sign operands whose result flips sign have left the signed range.
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef SIGNED_MAC_ACC_SAT_EN
        if (ovf) begin
            sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum = raw;
        end
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/signed_mac_acc.sv
// Frames a stream of signed 16-bit products into a signed sum, beat count and overflow flag.
// SIGNED_MAC_ACC_SAT_EN selects saturating accumulation (default: wrap).
module signed_mac_acc
    import mul_pkg::*;
#(
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned MAX_BEATS = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    mac_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] beat_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;
    logic             close;

    assign beat_ext = ACC_W'($signed(in_data));
    assign cnt_nxt  = cnt + CNT_W'(1);
    assign accept   = in_valid && in_ready;
    assign close    = in_last || (cnt_nxt == CNT_W'(MAX_BEATS));

    sat_add #(
        .W (ACC_W)
    ) u_add (
        .a   (acc),
        .b   (beat_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Frame FSM: accumulate in ACC, present a held result in OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc <= add_sum;
                        cnt <= cnt_nxt;
                        ovf <= ovf | add_ovf;
                        if (close) begin
                            state     <= OUT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= add_sum;
                            out_count <= cnt_nxt;
                            out_ovf   <= ovf | add_ovf;
                        end
                    end
                end
                OUT: begin
                    // Result fields stay frozen until the consumer takes them.
                    if (out_ready) begin
                        state     <= ACC;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACC;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_mac_acc.sv
// Directed bench for signed_mac_acc with ACC_W=16, MAX_BEATS=4.
module tb_signed_mac_acc;

    localparam int unsigned ACC_W     = 16;
    localparam int unsigned MAX_BEATS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [7:0]        out_count;
    logic              out_ovf;

    int vectors = 0;
    int errors  = 0;

    signed_mac_acc #(
        .ACC_W     (ACC_W),
        .MAX_BEATS (MAX_BEATS)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] sum32();
        return 32'($signed(out_sum));
    endfunction

    task automatic beat(input logic signed [15:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
    endtask

    task automatic release_result();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_in_ready", 32'(in_ready), 1);
        chk("release_out_valid", 32'(out_valid), 0);
    endtask

    initial begin
        logic signed [31:0] sat_exp;
`ifdef SIGNED_MAC_ACC_SAT_EN
        sat_exp = 32767;
`else
        sat_exp = -32768;
`endif
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        tick();
        chk("rst_sum", sum32(), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_sum", sum32(), 0);
        chk("reset_count", 32'(out_count), 0);
        chk("reset_ovf", 32'(out_ovf), 0);

        // Three-beat frame: 16384 - 16256 + 100 = 228
        beat(16'sd16384, 1'b0);
        beat(-16'sd16256, 1'b0);
        chk("f1_open", 32'(out_valid), 0);
        beat(16'sd100, 1'b1);
        in_valid = 1'b0;
        chk("f1_valid", 32'(out_valid), 1);
        chk("f1_in_ready", 32'(in_ready), 0);
        chk("f1_sum", sum32(), 228);
        chk("f1_count", 32'(out_count), 3);
        chk("f1_ovf", 32'(out_ovf), 0);
        release_result();

        // Positive overflow in a 16-bit accumulator
        beat(16'sd16384, 1'b0);
        beat(16'sd16384, 1'b1);
        in_valid = 1'b0;
        chk("ovf_valid", 32'(out_valid), 1);
        chk("ovf_flag", 32'(out_ovf), 1);
        chk("ovf_sum", sum32(), sat_exp);
        chk("ovf_count", 32'(out_count), 2);
        release_result();
        chk("ovf_cleared_next", 32'(out_valid), 0);

        // Back-pressure: result held while a beat waits at the input
        beat(16'sd5, 1'b0);
        beat(16'sd6, 1'b1);
        in_valid = 1'b1; in_data = 16'sd99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_sum", sum32(), 11);
            chk("bp_count", 32'(out_count), 2);
            chk("bp_ovf", 32'(out_ovf), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_back_to_acc", 32'(in_ready), 1);
        chk("bp_released", 32'(out_valid), 0);
        beat(16'sd1, 1'b1);
        in_valid = 1'b0;
        chk("bp_after_sum", sum32(), 1);
        chk("bp_after_count", 32'(out_count), 1);
        release_result();

        // Forced close at MAX_BEATS; beats 5 and 6 start the next frame
        for (int i = 0; i < 4; i++) beat(16'sd1, 1'b0);
        chk("force_valid", 32'(out_valid), 1);
        chk("force_sum", sum32(), 4);
        chk("force_count", 32'(out_count), 4);
        in_valid = 1'b1; in_data = 16'sd1; in_last = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("force_released", 32'(out_valid), 0);
        beat(16'sd1, 1'b0);
        beat(16'sd1, 1'b0);
        chk("force_next_open", 32'(out_valid), 0);
        beat(16'sd0, 1'b1);
        in_valid = 1'b0;
        chk("force_next_sum", sum32(), 2);
        chk("force_next_count", 32'(out_count), 3);
        release_result();

        // Reset aborts a partial frame
        beat(16'sd3, 1'b0);
        beat(16'sd4, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_sum", sum32(), 0);
        beat(-16'sd5, 1'b1);
        in_valid = 1'b0;
        chk("abort_next_valid", 32'(out_valid), 1);
        chk("abort_next_sum", sum32(), -5);
        chk("abort_next_count", 32'(out_count), 1);
        release_result();

        // Idle cycles inside a frame are ignored
        beat(16'sd7, 1'b0);
        in_valid = 1'b0; in_data = 16'sd1000; in_last = 1'b1;
        tick();
        tick();
        chk("gap_open", 32'(out_valid), 0);
        beat(16'sd8, 1'b1);
        in_valid = 1'b0;
        chk("gap_valid", 32'(out_valid), 1);
        chk("gap_sum", sum32(), 15);
        chk("gap_count", 32'(out_count), 2);
        release_result();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/signed_mac_acc.md
SIGNED_MAC_ACC -- requirements
Module: signed_mac_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 24: accumulator and result width in bits, legal range 16..32.
REQ-002 SHALL have parameter MAX_BEATS, default 255: maximum number of products per frame, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a product this cycle.
REQ-007 SHALL have port in_data, input, 16 bits: signed two's-complement product from the 8x8 signed multiplier stage.
REQ-008 SHALL have port in_last, input, 1 bit: this product is the final beat of the frame.
REQ-009 SHALL have port out_valid, output, 1 bit: the result fields are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port out_sum, output, ACC_W bits: signed frame sum.
REQ-012 SHALL have port out_count, output, 8 bits: number of beats in the frame.
REQ-013 SHALL have port out_ovf, output, 1 bit: at least one overflow occurred in the frame.

Function
REQ-014 SHALL implement a two-state FSM: ACC (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1).
REQ-015 SHALL accept a beat only when in_valid && in_ready; on accept, add sign-extended in_data to the accumulator and increment the beat count.
REQ-016 SHALL go from ACC to OUT on an accepted beat with in_last=1, or on an accepted beat that makes the count equal MAX_BEATS (forced close).
REQ-017 SHALL assert out_valid in the cycle after the closing beat is accepted (latency 1); out_sum already includes that beat.
REQ-018 SHALL hold out_sum, out_count and out_ovf stable while in OUT and out_ready=0.
REQ-019 SHALL, in OUT with out_ready=1, return to ACC the next cycle with accumulator, count and overflow flag cleared.
REQ-020 SHALL NOT accept an input beat in the same cycle as a result handshake; in_ready stays 0 for the whole of OUT.
REQ-021 SHALL detect overflow as: both operands have the same sign and the raw sum's sign differs; out_ovf is sticky until the frame is released.
REQ-022 SHALL ignore in_valid=0 cycles in ACC; the accumulator holds.
REQ-023 SHALL keep a frame open indefinitely while in_last is never asserted, up to MAX_BEATS.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, enter ACC with accumulator=0, count=0, ovf=0, out_valid=0 and in_ready=1 on the following cycle.
REQ-025 SHALL abort any partial frame or pending result on reset mid-operation, producing no output for it.
REQ-026 SHALL drive out_sum=0, out_count=0 and out_ovf=0 while in reset and until the first frame closes.

Configuration
REQ-027 SHALL support macro SIGNED_MAC_ACC_SAT_EN.
- Defined: on overflow the accumulator clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1).
- Undefined: the accumulator wraps modulo 2^ACC_W.
- out_ovf behaviour is identical in both cases.

Structure
REQ-028 SHALL place the FSM state typedef (ACC, OUT), the product width constant (16) and the beat-count width constant (8) in shared package mul_pkg.
REQ-029 SHALL use one sub-module, sat_add, a combinational ACC_W-bit signed adder returning sum and overflow, with clamping gated by SIGNED_MAC_ACC_SAT_EN.

Verification
REQ-030 SHALL cover: beats 16384, -16256, 100 with last on the third beat -> one cycle later out_valid=1, out_sum=228, out_count=3, out_ovf=0.
REQ-031 SHALL cover: ACC_W=16, beats 16384 then 16384 with last -> out_ovf=1; out_sum=32767 with SAT_EN defined, -32768 without.
REQ-032 SHALL cover: result pending, out_ready held 0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, outputs stable, no beat consumed; out_ready=1 -> ACC the next cycle.
REQ-033 SHALL cover: MAX_BEATS=4, six beats of value 1 with no last -> forced close with out_sum=4, out_count=4; the remaining two beats form the next frame.
REQ-034 SHALL cover: rst=1 after two accepted beats of a frame -> out_valid stays 0; next frame of single beat -5 with last -> out_sum=-5, out_count=1.
REQ-035 SHALL cover: in_valid toggled 1,0,0,1 with beats 7 and 8 (last on 8) -> out_sum=15, out_count=2.
